dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port, combinational-read data memory between the CPU (LW/SW) and one
//  read-only device port (display/DMA fetch). CPU has default priority; device is starvation-
//  protected by a wait counter that forces a device cycle. The CPU is frozen via cpu_enable,
//  which drives the controller's enable input, gating register-file and memory writes.
// PARAMETERS
//  AW        14   word-address width of data memory
//  MAX_WAIT  4    max consecutive denied device cycles before a forced device grant (>=1)
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  reset       in   1   asynchronous, active-high reset
//  cpu_req     in   1   CPU accesses memory this cycle (LW or SW)
//  cpu_wr      in   1   CPU access is a write (SW)
//  cpu_addr    in   AW  CPU word address
//  cpu_wdata   in   32  CPU store data
//  cpu_rdata   out  32  load data to CPU (mem_rdata passthrough)
//  cpu_enable  out  1   1 = CPU advances this cycle; 0 = CPU frozen
//  dev_req     in   1   device read request (level, held until granted)
//  dev_addr    in   AW  device word address
//  dev_gnt     out  1   device owns memory this cycle; dev_rdata valid this cycle
//  dev_rdata   out  32  read data to device (mem_rdata passthrough)
//  mem_addr    out  AW  memory address
//  mem_wr      out  1   memory write strobe
//  mem_wdata   out  32  memory write data (= cpu_wdata)
//  mem_rdata   in   32  memory read data, combinational from mem_addr
// BEHAVIOUR
//  - Clock clk; reset asynchronous, active-high. While reset=1: state=CPU_PRI, wait_cnt=0,
//    cpu_enable=0, dev_gnt=0, mem_wr=0, mem_addr=cpu_addr.
//  - FSM states: CPU_PRI (normal), DEV_FORCE (one-cycle forced device slot).
//  - Grant (combinational, same cycle, zero latency):
//      CPU_PRI:   dev_gnt = dev_req & ~cpu_req
//      DEV_FORCE: dev_gnt = dev_req
//  - cpu_enable = ~(dev_gnt & cpu_req). A CPU not requesting memory is never stalled.
//  - mem_addr = dev_gnt ? dev_addr : cpu_addr; mem_wr = cpu_req & cpu_wr & ~dev_gnt.
//  - Device is read-only; device never causes a write.
//  - wait_cnt ($clog2(MAX_WAIT+1) bits): clear when dev_req=0 or dev_gnt=1;
//    else increment, saturating at MAX_WAIT.
//  - Transitions:
//      CPU_PRI -> DEV_FORCE when dev_req & ~dev_gnt & (wait_cnt == MAX_WAIT-1)
//      DEV_FORCE -> CPU_PRI unconditionally after one cycle, even if dev_req dropped
//      (no grant then; wait_cnt clears).
//  - After a forced slot, CPU_PRI rules apply again, so the CPU always gets the next cycle.
//  - Worst-case device latency: MAX_WAIT denied cycles, grant on cycle MAX_WAIT+1.
//  - Worst-case CPU stall: 1 cycle per MAX_WAIT+1.
//  - Reset mid-forced-slot: returns to CPU_PRI immediately; no partial write possible
//    (mem_wr=0 in reset).
//  - Device burst (dev_req held, CPU idle): dev_gnt every cycle; dev_addr may change per cycle.
// CONFIGURATION
//  - ARB_STATS_EN defined: adds output stall_cnt [15:0].
//      Counts cycles with cpu_req=1 & cpu_enable=0; saturates at 16'hFFFF.
//      Cleared by reset only.
//  - ARB_STATS_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. Reset:
//     reset=1, cpu_req=1, dev_req=1 -> cpu_enable=0, dev_gnt=0, mem_wr=0;
//     release -> CPU_PRI, cpu_enable=1.
//  2. CPU store, no contention:
//     cpu_req=1, cpu_wr=1, cpu_addr=0x10, cpu_wdata=0xDEADBEEF, dev_req=0
//     -> mem_wr=1, mem_addr=0x10; readback LW returns 0xDEADBEEF.
//  3. Device alone:
//     dev_req=1, dev_addr=0x20 (mem[0x20]=0x12345678), cpu_req=0
//     -> dev_gnt=1 same cycle, dev_rdata=0x12345678.
//  4. Starvation, MAX_WAIT=4:
//     cpu_req=1 every cycle, dev_req=1 -> dev_gnt=0 for 4 cycles, then dev_gnt=1 and
//     cpu_enable=0 on cycle 5, cpu_enable=1 on cycle 6; pattern repeats every 5 cycles.
//  5. Forced slot while CPU storing:
//     cpu_wr=1 during DEV_FORCE -> mem_wr=0 that cycle; write lands the following cycle.
//  6. Device drop in DEV_FORCE:
//     dev_req falls entering forced slot -> dev_gnt=0, cpu_enable=1, wait_cnt=0, back to CPU_PRI.
//  With ARB_STATS_EN, scenario 4 over 20 cycles -> stall_cnt=4.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU has default priority, and a wait counter forces a one-cycle device slot.
// Optional stall statistics counter is enabled by defining ARB_STATS_EN.
module dmem_arbiter #(
  parameter int AW       = 14,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_enable,
  input  logic          dev_req,
  input  logic [AW-1:0] dev_addr,
  output logic          dev_gnt,
  output logic [31:0]   dev_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
  localparam logic [CW-1:0] WAIT_MAX  = CW'(MAX_WAIT);

  typedef enum logic {CPU_PRI, DEV_FORCE} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          gnt;

  function automatic logic [CW-1:0] sat_inc_wait(input logic [CW-1:0] v);
    return (v == WAIT_MAX) ? v : v + 1'b1;
  endfunction

  // Grant is resolved in the same cycle; reset suppresses every control output.
  always_comb begin
    gnt = 1'b0;
    if (!reset) begin
      if (state == DEV_FORCE) gnt = dev_req;
      else                    gnt = dev_req & ~cpu_req;
    end
  end

  assign dev_gnt    = gnt;
  assign cpu_enable = ~reset & ~(gnt & cpu_req);
  assign mem_addr   = gnt ? dev_addr : cpu_addr;
  assign mem_wr     = ~reset & cpu_req & cpu_wr & ~gnt;
  assign mem_wdata  = cpu_wdata;
  assign cpu_rdata  = mem_rdata;
  assign dev_rdata  = mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= CPU_PRI;
      wait_cnt <= '0;
    end else begin
      case (state)
        CPU_PRI:   if (dev_req && !gnt && wait_cnt == WAIT_LAST) state <= DEV_FORCE;
        DEV_FORCE: state <= CPU_PRI;
        default:   state <= CPU_PRI;
      endcase
      if (!dev_req || gnt) wait_cnt <= '0;
      else                 wait_cnt <= sat_inc_wait(wait_cnt);
    end
  end

`ifdef ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     stall_cnt <= '0;
    else if (cpu_req && !cpu_enable) stall_cnt <= sat_inc16(stall_cnt);
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory, a vector table fed through an expectation queue,
// plus hand-written reset sequences.
module tb_dmem_arbiter;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_wr, dev_req;
  logic [AW-1:0] cpu_addr, dev_addr, mem_addr;
  logic [31:0]   cpu_wdata, cpu_rdata, dev_rdata, mem_wdata, mem_rdata;
  logic          cpu_enable, dev_gnt, mem_wr;
`ifdef ARB_STATS_EN
  logic [15:0]   stall_cnt;
`endif

  logic [31:0] mem [0:(1<<AW)-1];

  int checks   = 0;
  int failures = 0;

  dmem_arbiter #(.AW(AW), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_enable(cpu_enable),
    .dev_req(dev_req), .dev_addr(dev_addr), .dev_gnt(dev_gnt), .dev_rdata(dev_rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

  typedef struct {
    bit          creq, cwr;
    logic [AW-1:0] caddr;
    logic [31:0] cwdata;
    bit          dreq;
    logic [AW-1:0] daddr;
    bit          e_gnt, e_en, e_wr;
    logic [AW-1:0] e_addr;
    bit          chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input bit creq, input bit cwr, input logic [AW-1:0] caddr,
                     input logic [31:0] cwdata, input bit dreq, input logic [AW-1:0] daddr,
                     input bit e_gnt, input bit e_en, input bit e_wr,
                     input logic [AW-1:0] e_addr, input bit chk_rd, input logic [31:0] e_rd);
    vec_t v;
    v.creq = creq; v.cwr = cwr; v.caddr = caddr; v.cwdata = cwdata;
    v.dreq = dreq; v.daddr = daddr;
    v.e_gnt = e_gnt; v.e_en = e_en; v.e_wr = e_wr; v.e_addr = e_addr;
    v.chk_rd = chk_rd; v.e_rd = e_rd;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    cpu_req = v.creq; cpu_wr = v.cwr; cpu_addr = v.caddr; cpu_wdata = v.cwdata;
    dev_req = v.dreq; dev_addr = v.daddr;
    exp_q.push_back(v);
  endtask

  task automatic compare(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s.queue: got empty expected entry", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, ".gnt"},  {31'd0, dev_gnt},    {31'd0, e.e_gnt});
    check({tag, ".en"},   {31'd0, cpu_enable}, {31'd0, e.e_en});
    check({tag, ".wr"},   {31'd0, mem_wr},     {31'd0, e.e_wr});
    check({tag, ".addr"}, {18'd0, mem_addr},   {18'd0, e.e_addr});
    if (e.chk_rd) begin
      if (e.e_gnt) check({tag, ".dev_rdata"}, dev_rdata, e.e_rd);
      else         check({tag, ".cpu_rdata"}, cpu_rdata, e.e_rd);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(posedge clk); #1;
    drive(v);
    @(negedge clk);
    compare(tag);
  endtask

  initial begin
    int exp_stalls;
    vec_t v;
    mem[14'h10] = 32'h0;
    mem[14'h20] = 32'h12345678;
    mem[14'h21] = 32'hA5A50001;
    mem[14'h30] = 32'h0;

    // Reset asserted with both requesters active
    reset = 1'b1;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 14'h7; cpu_wdata = 32'h11111111;
    dev_req = 1'b1; dev_addr = 14'h20;
    repeat (2) @(negedge clk);
    check("rst.en",   {31'd0, cpu_enable}, 32'd0);
    check("rst.gnt",  {31'd0, dev_gnt},    32'd0);
    check("rst.wr",   {31'd0, mem_wr},     32'd0);
    check("rst.addr", {18'd0, mem_addr},   32'h7);
`ifdef ARB_STATS_EN
    check("rst.stall", {16'd0, stall_cnt}, 32'd0);
`endif
    #1 reset = 1'b0;

    // Store / load, device alone, burst, idle
    add(1,1,14'h10,32'hDEADBEEF,0,14'h0,  0,1,1,14'h10, 0,32'h0);
    add(1,0,14'h10,32'h0,0,14'h0,         0,1,0,14'h10, 1,32'hDEADBEEF);
    add(0,0,14'h5,32'h0,1,14'h20,         1,1,0,14'h20, 1,32'h12345678);
    add(0,0,14'h5,32'h0,1,14'h21,         1,1,0,14'h21, 1,32'hA5A50001);
    add(0,0,14'h5,32'h0,0,14'h21,         0,1,0,14'h5,  0,32'h0);
    // Starvation: four denials then a forced slot, twice
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++)
        add(1,0,14'h10,32'h0,1,14'h20,    0,1,0,14'h10, 1,32'hDEADBEEF);
      add(1,0,14'h10,32'h0,1,14'h20,      1,0,0,14'h20, 1,32'h12345678);
    end
    // Forced slot during a CPU store: write deferred one cycle
    for (int i = 0; i < 4; i++)
      add(1,1,14'h30,32'hCAFE0000,1,14'h20, 0,1,1,14'h30, 0,32'h0);
    add(1,1,14'h30,32'hCAFE0001,1,14'h20,   1,0,0,14'h20, 1,32'h12345678);
    add(1,1,14'h30,32'hCAFE0001,1,14'h20,   0,1,1,14'h30, 0,32'h0);
    add(1,0,14'h30,32'h0,0,14'h20,          0,1,0,14'h30, 1,32'hCAFE0001);
    // Device drops as the forced slot starts; counter must restart from zero
    for (int i = 0; i < 4; i++)
      add(1,0,14'h10,32'h0,1,14'h20,      0,1,0,14'h10, 1,32'hDEADBEEF);
    add(1,0,14'h10,32'h0,0,14'h20,        0,1,0,14'h10, 1,32'hDEADBEEF);
    for (int i = 0; i < 4; i++)
      add(1,0,14'h10,32'h0,1,14'h21,      0,1,0,14'h10, 1,32'hDEADBEEF);
    add(1,0,14'h10,32'h0,1,14'h21,        1,0,0,14'h21, 1,32'hA5A50001);
    // CPU idle right after a forced slot: device keeps the port
    add(0,0,14'h10,32'h0,1,14'h20,        1,1,0,14'h20, 1,32'h12345678);

    exp_stalls = 0;
    foreach (vecs[i]) begin
      if (vecs[i].creq && !vecs[i].e_en) exp_stalls++;
      apply(vecs[i], $sformatf("v%0d", i));
    end
`ifdef ARB_STATS_EN
    check("stall_cnt", {16'd0, stall_cnt}, exp_stalls);
`endif

    // Reset in the middle of a forced slot while the CPU stores
    for (int i = 0; i < 4; i++) begin
      v = vecs[5];
      apply(v, $sformatf("pre%0d", i));
    end
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 14'h40; cpu_wdata = 32'h55555555;
    dev_req = 1'b1; dev_addr = 14'h20;
    #1 reset = 1'b1;
    @(negedge clk);
    check("midrst.gnt",  {31'd0, dev_gnt},    32'd0);
    check("midrst.wr",   {31'd0, mem_wr},     32'd0);
    check("midrst.en",   {31'd0, cpu_enable}, 32'd0);
    check("midrst.addr", {18'd0, mem_addr},   32'h40);
`ifdef ARB_STATS_EN
    check("midrst.stall", {16'd0, stall_cnt}, 32'd0);
`endif
    #1 reset = 1'b0;
    v.creq = 1; v.cwr = 1; v.caddr = 14'h40; v.cwdata = 32'h55555555;
    v.dreq = 1; v.daddr = 14'h20;
    v.e_gnt = 0; v.e_en = 1; v.e_wr = 1; v.e_addr = 14'h40; v.chk_rd = 0; v.e_rd = 32'h0;
    apply(v, "postrst");
    v.cwr = 0; v.chk_rd = 1; v.e_wr = 0; v.e_rd = 32'h55555555;
    apply(v, "postrst_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
